instr_fetch_buffer: RTL and testbench

//  Sequential instruction fetcher feeding the CPU decode stage. Drives read-only

---
 rtl/instr_fetch_buffer.sv | 179 +++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Sequential instruction fetcher for the decode stage. Issues word reads
//   to a fixed-latency memory port, tracks them in a small shift register
//   tagged with a 1-bit epoch, and queues returned {pc, word} pairs in an
//   output FIFO on a valid/ready port. A redirect flushes the FIFO, clears
//   the tracker and flips the epoch so that no stale word is ever delivered.
//   Optional build macro: FETCH_PERF_EN adds the stall_count output, which
//   counts the cycles in which issue was held off by exhausted credits.
module instr_fetch_buffer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + MEM_LATENCY) + 1;
    localparam int LAST  = MEM_LATENCY - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Fetch control
    logic [31:0]      fetch_pc;
    logic             cur_epoch;
    logic             credit_ok;

    // Tracker: one entry per memory pipeline stage, index 0 = just issued
    logic             trk_vld_p   [MEM_LATENCY];
    logic [31:0]      trk_pc_p    [MEM_LATENCY];
    logic             trk_epoch_p [MEM_LATENCY];
    logic [CNT_W-1:0] inflight_count;

    // Output FIFO
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Count reads still travelling through the memory pipeline.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_count = inflight_count + CNT_W'(trk_vld_p[i]);
        end
    end

    // Issue decision: a read is only launched when a FIFO slot is reserved
    // for it, counting both buffered words and reads still in flight.
    always_comb begin
        credit_ok = (fifo_count + inflight_count) < DEPTH_C;
        mem_en    = !reset && !redirect_valid && credit_ok;
        mem_addr  = fetch_pc;
        mem_we    = 1'b0;
        mem_din   = '0;
    end

    // Fetch pointer and epoch: redirect wins over sequential advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            cur_epoch <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc;
            cur_epoch <= ~cur_epoch;
        end else if (mem_en) begin
            fetch_pc  <= fetch_pc + 32'd1;
        end
    end

    // ---- stage boundary: issue -> memory pipeline (tracker valid bits) ----
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                trk_vld_p[i] <= 1'b0;
            end
        end else begin
            trk_vld_p[0] <= mem_en;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                trk_vld_p[i] <= trk_vld_p[i-1];
            end
        end
    end

    // Tracker payload shifts every cycle; only the valid bits need reset.
    always_ff @(posedge clock) begin
        trk_pc_p[0]    <= fetch_pc;
        trk_epoch_p[0] <= cur_epoch;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            trk_pc_p[i]    <= trk_pc_p[i-1];
            trk_epoch_p[i] <= trk_epoch_p[i-1];
        end
    end

    // ---- stage boundary: memory response -> output FIFO ----
    always_comb begin
        push        = !reset && !redirect_valid && trk_vld_p[LAST] &&
                      (trk_epoch_p[LAST] == cur_epoch);
        instr_valid = (fifo_count != '0);
        pop         = instr_valid && instr_ready;
        fifo_full   = (fifo_count == DEPTH_C);
        instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
        instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
    end

    // FIFO storage: written on push, no reset needed since reads are gated by valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_dout;
            fifo_pc[wr_ptr]   <= trk_pc_p[LAST];
        end
    end

    // FIFO pointers and occupancy; redirect flushes just like reset.
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The credit scheme makes overflow impossible; catch it if that ever breaks.
    assert property (@(posedge clock) disable iff (reset) !(push && fifo_full));

`ifdef FETCH_PERF_EN
    logic stall_now;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A throttled cycle is one where issue was possible except for credits.
    always_comb begin
        stall_now = !reset && !redirect_valid && !credit_ok;
    end

    // Saturating count of throttled cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_now) begin
            stall_count <= sat_inc32(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: 2-cycle memory model returning addr+100,
// expected-pc scoreboard checked on every accepted handshake.
`timescale 1ns/1ps
module tb_instr_fetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_count;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_r1 = '0;

    instr_fetch_buffer #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4),
        .MEM_LATENCY(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    always #5 clock = ~clock;

    // Memory port 1: mem[i] = i + 100, sampled on one edge, visible after the next.
    always @(posedge clock) begin
        if (mem_en) mem_r1 <= mem_addr + 32'd100;
        mem_dout <= mem_r1;
    end

    // Scoreboard: every accepted word must be the next expected pc with its data.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clock);
            if (!reset && !redirect_valid && instr_valid && instr_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got pc=%h data=%h, required no delivery", instr_pc, instr_data);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (instr_pc !== exp_pc || instr_data !== exp_pc + 32'd100) begin
                        fails++;
                        $display("FAIL sb_word: got pc=%h data=%h, required pc=%h data=%h",
                                 instr_pc, instr_data, exp_pc, exp_pc + 32'd100);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
    endtask

    // Hold ready high until the scoreboard queue drains or the budget expires.
    task automatic run_stream(input int max_cycles, output int gaps, output bit done);
        gaps = 0;
        done = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            if (!instr_valid) gaps++;
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en: got %b, required 0", mem_en); end
        tests++; if (mem_addr !== RESET_PC) begin fails++; $display("FAIL reset_mem_addr: got %h, required %h", mem_addr, RESET_PC); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b, required 0", instr_valid); end
        tests++; if (instr_data !== 32'd0) begin fails++; $display("FAIL reset_instr_data: got %h, required 0", instr_data); end
        tests++; if (instr_pc !== 32'd0) begin fails++; $display("FAIL reset_instr_pc: got %h, required 0", instr_pc); end
        tests++; if (mem_we !== 1'b0 || mem_din !== 32'd0) begin fails++; $display("FAIL reset_mem_tie: got we=%b din=%h, required 0/0", mem_we, mem_din); end
`ifdef FETCH_PERF_EN
        tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall_count: got %0d, required 0", stall_count); end
`endif
    endtask

    task automatic test_first_word_and_stream();
        int edges;
        int gaps;
        bit done;
        push_seq(32'd0, 20);
        instr_ready = 1'b1;
        reset = 1'b0;
        #1;
        tests++; if (mem_en !== 1'b1 || mem_addr !== RESET_PC) begin fails++; $display("FAIL first_issue: got en=%b addr=%h, required 1/%h", mem_en, mem_addr, RESET_PC); end
        edges = 0;
        while (!instr_valid && edges < 10) begin
            tick();
            edges++;
        end
        tests++; if (edges !== 3) begin fails++; $display("FAIL first_latency: got %0d edges, required 3", edges); end
        tests++; if (instr_pc !== 32'd0 || instr_data !== 32'd100) begin fails++; $display("FAIL first_word: got pc=%h data=%h, required 0/100", instr_pc, instr_data); end
        run_stream(40, gaps, done);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL stream_done: got %0d left, required 0", exp_q.size()); end
        tests++; if (gaps !== 0) begin fails++; $display("FAIL stream_gaps: got %0d, required 0", gaps); end
    endtask

    task automatic test_backpressure();
        int changes;
        int gaps;
        bit done;
        do_reset();
        push_seq(32'd0, 16);
        reset = 1'b0;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_valid && (instr_pc !== 32'd0 || instr_data !== 32'd100)) changes++;
        end
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL bp_throttle: got mem_en=%b, required 0", mem_en); end
        tests++; if (mem_addr !== 32'd4) begin fails++; $display("FAIL bp_buffered: got next addr %h, required 4", mem_addr); end
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b, required 1", instr_valid); end
        tests++; if (changes !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes, required 0", changes); end
        run_stream(60, gaps, done);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done: got %0d left, required 0", exp_q.size()); end
        tests++; if (gaps !== 0) begin fails++; $display("FAIL bp_gaps: got %0d, required 0", gaps); end
    endtask

    task automatic test_redirect();
        int gaps;
        bit done;
        do_reset();
        push_seq(32'd0, 4);
        reset = 1'b0;
        repeat (4) tick();
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || mem_en !== 1'b0) begin fails++; $display("FAIL redir_setup: got valid=%b pc=%h en=%b, required 1/0/0", instr_valid, instr_pc, mem_en); end
        exp_q.delete();
        push_seq(32'h40, 8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_flush: got valid=%b, required 0", instr_valid); end
        tests++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin fails++; $display("FAIL redir_issue: got en=%b addr=%h, required 1/40", mem_en, mem_addr); end
        run_stream(40, gaps, done);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL redir_done: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back_redirect();
        int gaps;
        bit done;
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_pc = 32'h20;
        push_seq(32'h20, 8);
        #1;
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL b2b_no_issue: got en=%b, required 0", mem_en); end
        tick();
        redirect_valid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL b2b_flush: got valid=%b, required 0", instr_valid); end
        tests++; if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin fails++; $display("FAIL b2b_issue: got en=%b addr=%h, required 1/20", mem_en, mem_addr); end
        run_stream(40, gaps, done);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_pc_wrap();
        int gaps;
        bit done;
        exp_q.delete();
        push_seq(32'hFFFF_FFFE, 6);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        run_stream(40, gaps, done);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL wrap_done: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        int gaps;
        bit done;
        do_reset();
        push_seq(32'd0, 100);
        reset = 1'b0;
        instr_ready = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tests++; if (instr_valid !== 1'b0 || instr_data !== 32'd0 || instr_pc !== 32'd0) begin fails++; $display("FAIL mreset_out: got valid=%b data=%h pc=%h, required 0/0/0", instr_valid, instr_data, instr_pc); end
        tests++; if (mem_en !== 1'b0 || mem_addr !== RESET_PC) begin fails++; $display("FAIL mreset_mem: got en=%b addr=%h, required 0/%h", mem_en, mem_addr, RESET_PC); end
        reset = 1'b0;
        push_seq(RESET_PC, 8);
        #1;
        tests++; if (mem_en !== 1'b1 || mem_addr !== RESET_PC) begin fails++; $display("FAIL mreset_refetch: got en=%b addr=%h, required 1/%h", mem_en, mem_addr, RESET_PC); end
        run_stream(40, gaps, done);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL mreset_done: got %0d left, required 0", exp_q.size()); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        int gaps;
        bit done;
        do_reset();
        reset = 1'b0;
        repeat (14) tick();
        tests++; if (stall_count !== 32'd10) begin fails++; $display("FAIL perf_throttled: got %0d, required 10", stall_count); end
        push_seq(32'd0, 40);
        instr_ready = 1'b1;
        tick();
        tests++; if (stall_count !== 32'd11) begin fails++; $display("FAIL perf_last_stall: got %0d, required 11", stall_count); end
        repeat (10) tick();
        tests++; if (stall_count !== 32'd11) begin fails++; $display("FAIL perf_streaming: got %0d, required 11", stall_count); end
        run_stream(60, gaps, done);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL perf_done: got %0d left, required 0", exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_word_and_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back_redirect();
        test_pc_wrap();
        test_mid_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
